clkwiz_reg_slave: RTL and testbench

- AXI4-Lite responder modelling the Clock Wizard dynamic-reconfiguration register file (PG065 subset: VCO 0x200, DIV 0x208, CONFIG 0x25C) plus a STATUS register.
- Used as the bench/emulation target for our AXI4-Lite clock-management masters, and as a soft register front-end for fixed-clock builds.
- Applies register contents to "active" outputs after a modelled lock sequence, with the `locked` output dropping during the sequence.

---
 rtl/clkwiz_reg_slave.sv | 187 ++++++++++++++++++
 tb/tb_clkwiz_reg_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clkwiz_reg_slave.sv
`default_nettype none
// clkwiz_reg_slave: AXI4-Lite model of the Clock Wizard reconfiguration registers
// with a modelled lock sequence driving the active VCO/DIV outputs. Revision 1.0
module clkwiz_reg_slave #(
  parameter int          DW          = 32,
  parameter int          AW          = 12,
  parameter logic [31:0] VCO_DEFAULT = 32'h0000_0A01,
  parameter logic [31:0] DIV_DEFAULT = 32'h0000_0005,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   S_AXI_AWADDR,
  input  logic            S_AXI_AWVALID,
  input  logic [2:0]      S_AXI_AWPROT,
  output logic            S_AXI_AWREADY,
  input  logic [DW-1:0]   S_AXI_WDATA,
  input  logic [DW/8-1:0] S_AXI_WSTRB,
  input  logic            S_AXI_WVALID,
  output logic            S_AXI_WREADY,
  output logic [1:0]      S_AXI_BRESP,
  output logic            S_AXI_BVALID,
  input  logic            S_AXI_BREADY,
  input  logic [AW-1:0]   S_AXI_ARADDR,
  input  logic [2:0]      S_AXI_ARPROT,
  input  logic            S_AXI_ARVALID,
  output logic            S_AXI_ARREADY,
  output logic [DW-1:0]   S_AXI_RDATA,
  output logic [1:0]      S_AXI_RRESP,
  output logic            S_AXI_RVALID,
  input  logic            S_AXI_RREADY,
  output logic [31:0]     active_vco,
  output logic [31:0]     active_div,
  output logic            locked,
  output logic            reconfig_done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam int          c_cw        = $clog2(LOCK_CYCLES + 1);
  localparam logic [1:0]  c_okay      = 2'b00;
  localparam logic [1:0]  c_slverr    = 2'b10;
  localparam logic [AW-1:0] c_b_status = AW'(32'h004);
  localparam logic [AW-1:0] c_b_vco    = AW'(32'h200);
  localparam logic [AW-1:0] c_b_div    = AW'(32'h208);
  localparam logic [AW-1:0] c_b_cfg    = AW'(32'h25C);

  state_t            r_state, w_state_next;
  logic [c_cw-1:0]   r_cnt;
  logic              r_rst_done;
  logic              r_aw_held, r_w_held;
  logic [AW-3:0]     r_awaddr;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_wstrb;
  logic [31:0]       r_vco, r_div;
  logic [7:0]        r_cfg;

  logic              w_commit, w_busy, w_cfg_start;
  logic              w_wr_status, w_wr_vco, w_wr_div, w_wr_cfg;
  logic [AW-3:0]     w_rd_word;
  logic [DW-1:0]     w_rdata;
  logic [1:0]        w_rresp;
  logic              w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Ready outputs stay low until the first edge out of reset.
  assign S_AXI_AWREADY = r_rst_done & ~r_aw_held & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = r_rst_done & ~r_w_held  & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = r_rst_done & ~S_AXI_RVALID;

  assign w_busy      = (r_state == ST_BUSY);
  assign w_commit    = r_aw_held & r_w_held;
  assign w_wr_status = (r_awaddr == c_b_status[AW-1:2]);
  assign w_wr_vco    = (r_awaddr == c_b_vco[AW-1:2]);
  assign w_wr_div    = (r_awaddr == c_b_div[AW-1:2]);
  assign w_wr_cfg    = (r_awaddr == c_b_cfg[AW-1:2]);
  assign w_cfg_start = w_commit & w_wr_cfg & ~w_busy & r_wstrb[0] & r_wdata[0];
  assign w_rd_word   = S_AXI_ARADDR[AW-1:2];

  always_comb begin
    w_rdata = '0;
    w_rresp = c_okay;
    if (w_rd_word == c_b_status[AW-1:2])   w_rdata = {{(DW-1){1'b0}}, locked};
    else if (w_rd_word == c_b_vco[AW-1:2]) w_rdata = r_vco;
    else if (w_rd_word == c_b_div[AW-1:2]) w_rdata = r_div;
    else if (w_rd_word == c_b_cfg[AW-1:2]) w_rdata = w_busy ? {{(DW-8){1'b0}}, r_cfg} : '0;
    else                                   w_rresp = c_slverr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_BUSY;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_cfg_start) w_state_next = ST_BUSY;
      ST_BUSY: if (r_cnt == '0) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rst_done    <= 1'b0;
      r_aw_held     <= 1'b0;
      r_w_held      <= 1'b0;
      r_awaddr      <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= c_okay;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= c_okay;
      r_vco         <= VCO_DEFAULT;
      r_div         <= DIV_DEFAULT;
      r_cfg         <= '0;
      active_vco    <= VCO_DEFAULT;
      active_div    <= DIV_DEFAULT;
      locked        <= 1'b0;
      reconfig_done <= 1'b0;
      r_cnt         <= c_cw'(LOCK_CYCLES);
    end else begin
      r_rst_done    <= 1'b1;
      reconfig_done <= 1'b0;

      if (S_AXI_AWVALID && S_AXI_AWREADY) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= S_AXI_AWADDR[AW-1:2];
      end
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        r_w_held <= 1'b1;
        r_wdata  <= S_AXI_WDATA;
        r_wstrb  <= S_AXI_WSTRB;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;

      if (w_commit) begin
        r_aw_held    <= 1'b0;
        r_w_held     <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= c_okay;
        if (w_wr_vco) begin
          for (int b = 0; b < DW/8; b++)
            if (r_wstrb[b]) r_vco[8*b +: 8] <= r_wdata[8*b +: 8];
        end else if (w_wr_div) begin
          for (int b = 0; b < DW/8; b++)
            if (r_wstrb[b]) r_div[8*b +: 8] <= r_wdata[8*b +: 8];
        end else if (w_wr_cfg) begin
          if (w_busy)          S_AXI_BRESP <= c_slverr;
          else if (r_wstrb[0]) r_cfg <= r_wdata[7:0];
        end else if (!w_wr_status) begin
          S_AXI_BRESP <= c_slverr;
        end
      end

      // VCO/DIV are sampled on the completion edge, so late writes still land.
      if (w_cfg_start) begin
        locked <= 1'b0;
        r_cnt  <= c_cw'(LOCK_CYCLES);
      end else if (w_busy) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          active_vco    <= r_cfg[1] ? r_vco : VCO_DEFAULT;
          active_div    <= r_cfg[1] ? r_div : DIV_DEFAULT;
          locked        <= 1'b1;
          r_cfg         <= '0;
          reconfig_done <= 1'b1;
        end
      end

      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= w_rdata;
        S_AXI_RRESP  <= w_rresp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clkwiz_reg_slave.sv
`default_nettype none
// tb_clkwiz_reg_slave: directed self-checking bench for clkwiz_reg_slave.
// Revision 1.0
module tb_clkwiz_reg_slave;

  logic        clk;
  logic        resetn;
  logic [11:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [11:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] active_vco;
  logic [31:0] active_div;
  logic        locked;
  logic        reconfig_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  clkwiz_reg_slave dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .active_vco(active_vco), .active_div(active_div),
    .locked(locked), .reconfig_done(reconfig_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int bcyc);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int n = 0;
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA  = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1; n++;
      if (aw_hs) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  S_AXI_WVALID  = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(posedge clk); #1; n++; end
    check("b_valid_seen", S_AXI_BVALID, 1);
    resp = S_AXI_BRESP;
    bcyc = cyc;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit hs = 0;
    int n = 0;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!hs && n < 50) begin
      hs = S_AXI_ARREADY;
      @(posedge clk); #1; n++;
    end
    S_AXI_ARVALID = 1'b0;
    check("r_latency", S_AXI_RVALID, 1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic wait_lock(output int tl, output int pulses);
    int n = 0;
    tl = -1000;
    pulses = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (reconfig_done) pulses++;
      if (locked) begin tl = cyc; break; end
    end
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, br;
  int          bc, bc1, tl, pl, trel;

  initial begin
    resetn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = 3'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'b0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_wready", S_AXI_WREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_bresp", S_AXI_BRESP, 0);
    check("rst_rresp", S_AXI_RRESP, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_locked", locked, 0);
    check("rst_done", reconfig_done, 0);
    check("rst_active_vco", active_vco, 32'h0000_0A01);
    check("rst_active_div", active_div, 32'h0000_0005);

    // Power-up lock sequence
    trel = cyc;
    resetn = 1'b1;
    wait_lock(tl, pl);
    check("pwrup_lock_len", tl - trel, 17);
    check("pwrup_done_pulses", pl, 1);
    check("pwrup_vco", active_vco, 32'h0000_0A01);
    check("pwrup_div", active_div, 32'h0000_0005);
    @(posedge clk); #1;
    check("pwrup_done_low", reconfig_done, 0);

    // Register reads after lock
    axi_read(12'h200, rd, rr); check("rd_vco", rd, 32'h0000_0A01); check("rd_vco_resp", rr, 2'b00);
    axi_read(12'h208, rd, rr); check("rd_div", rd, 32'h0000_0005); check("rd_div_resp", rr, 2'b00);
    axi_read(12'h004, rd, rr); check("rd_status", rd, 32'h1);     check("rd_status_resp", rr, 2'b00);

    // DIV=8 then CONFIG LOAD|SADDR
    axi_write(12'h208, 32'h8, 4'hF, br, bc); check("wr_div8_resp", br, 2'b00);
    axi_write(12'h25C, 32'h3, 4'hF, br, bc); check("wr_cfg3_resp", br, 2'b00);
    check("cfg3_locked_low", locked, 0);
    axi_read(12'h25C, rd, rr); check("rd_cfg_busy", rd, 32'h3);
    wait_lock(tl, pl);
    check("cfg3_lock_len", tl - bc, 17);
    check("cfg3_done_pulses", pl, 1);
    check("cfg3_active_div", active_div, 32'h8);
    check("cfg3_active_vco", active_vco, 32'h0000_0A01);
    axi_read(12'h25C, rd, rr); check("rd_cfg_idle", rd, 32'h0); check("rd_cfg_idle_resp", rr, 2'b00);

    // CONFIG LOAD without SADDR restores defaults
    axi_write(12'h25C, 32'h1, 4'hF, br, bc); check("wr_cfg1_resp", br, 2'b00);
    wait_lock(tl, pl);
    check("cfg1_lock_len", tl - bc, 17);
    check("cfg1_active_div", active_div, 32'h5);
    check("cfg1_active_vco", active_vco, 32'h0000_0A01);
    axi_read(12'h208, rd, rr); check("rd_div_kept", rd, 32'h8);

    // AW three cycles ahead of W, BREADY held low, partial strobe to VCO
    S_AXI_AWADDR = 12'h200; S_AXI_AWVALID = 1'b1;
    check("split_awready", S_AXI_AWREADY, 1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    check("split_aw_held", S_AXI_AWREADY, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("split_no_early_b", S_AXI_BVALID, 0);
    S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = 4'b0011; S_AXI_WVALID = 1'b1;
    check("split_wready", S_AXI_WREADY, 1);
    @(posedge clk); #1;
    S_AXI_WVALID = 1'b0;
    @(posedge clk); #1;
    check("split_bvalid", S_AXI_BVALID, 1);
    check("split_bresp", S_AXI_BRESP, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("split_b_hold", S_AXI_BVALID, 1);
      check("split_aw_blocked", S_AXI_AWREADY, 0);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    check("split_b_clear", S_AXI_BVALID, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("split_single_commit", S_AXI_BVALID, 0);
    axi_read(12'h200, rd, rr); check("rd_vco_strb", rd, 32'h0000_5678);

    // Unmapped address
    axi_write(12'h100, 32'hFFFF_FFFF, 4'hF, br, bc); check("wr_bad_resp", br, 2'b10);
    axi_read(12'h200, rd, rr); check("bad_vco_unchanged", rd, 32'h0000_5678);
    axi_read(12'h208, rd, rr); check("bad_div_unchanged", rd, 32'h8);
    axi_read(12'h100, rd, rr); check("rd_bad_data", rd, 32'h0); check("rd_bad_resp", rr, 2'b10);

    // CONFIG rejected while busy, DIV write during busy lands at completion
    axi_write(12'h25C, 32'h3, 4'hF, br, bc1); check("busy_cfg_first_resp", br, 2'b00);
    axi_write(12'h25C, 32'h3, 4'hF, br, bc);  check("busy_cfg_again_resp", br, 2'b10);
    axi_write(12'h208, 32'h2, 4'hF, br, bc);  check("busy_div_resp", br, 2'b00);
    check("busy_locked_low", locked, 0);
    wait_lock(tl, pl);
    check("busy_lock_len", tl - bc1, 17);
    check("busy_done_pulses", pl, 1);
    check("busy_active_div", active_div, 32'h2);
    check("busy_active_vco", active_vco, 32'h0000_5678);
    axi_read(12'h004, rd, rr); check("rd_status_end", rd, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
